// File: rtl/controle_jogo.sv
// Game controller for the breakout-style game: start/launch/pause handling,
// lives and score bookkeeping, frame tick generation and restart/launch pulses.
module controle_jogo #(
    parameter int unsigned VIDAS_INICIAIS = 3,
    parameter int unsigned TICK_DIV       = 833333,
    parameter int unsigned PONTOS_BLOCO   = 10,
    parameter int unsigned ATRASO_FRAMES  = 60
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [3:0]  keysout,
    input  logic        bola_perdida,
    input  logic        bloco_destruido,
    input  logic        sem_blocos,
    output logic        pausa,
    output logic        reiniciarJogo,
    output logic        iniciarBola,
    output logic [1:0]  vidas,
    output logic [15:0] pontos,
    output logic [2:0]  estado,
    output logic        tick_frame
);

    localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned FRAME_W = (ATRASO_FRAMES > 0) ? $clog2(ATRASO_FRAMES + 1) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(ATRASO_FRAMES - 1);
    localparam logic [1:0]         VIDAS_INI  = 2'(VIDAS_INICIAIS);
    localparam logic [16:0]        PONTOS_INC = 17'(PONTOS_BLOCO);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVE   = 3'd1,
        PLAY    = 3'd2,
        PAUSADO = 3'd3,
        PERDEU  = 3'd4,
        FIM     = 3'd5,
        VITORIA = 3'd6
    } estado_t;

    estado_t            estado_q, estado_d;
    logic               pausa_q, pausa_d;
    logic               reinicia_q, reinicia_d;
    logic               inicia_q, inicia_d;
    logic [1:0]         vidas_q, vidas_d;
    logic [15:0]        pontos_q, pontos_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [TICK_W-1:0]  tick_cnt_q;
    logic               tick_frame_q;
    logic [1:0]         key_q;
    logic               start_press;
    logic               pause_press;
    logic [16:0]        pontos_soma;
    logic [15:0]        pontos_sat;
    logic               unused_keys;

    assign unused_keys = ^keysout[1:0];

    // Key level history; loading the live level under reset means a key held
    // through reset release does not register as a press.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_q <= keysout[3:2];
        end else begin
            key_q <= keysout[3:2];
        end
    end

    assign start_press = keysout[2] & ~key_q[0];
    assign pause_press = keysout[3] & ~key_q[1];

    // Free-running frame divider, one-cycle pulse every TICK_DIV cycles.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            tick_cnt_q   <= '0;
            tick_frame_q <= 1'b0;
        end else begin
            tick_frame_q <= (tick_cnt_q == TICK_LAST);
            tick_cnt_q   <= (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TICK_W'(1);
        end
    end

    // Saturating score increment.
    assign pontos_soma = {1'b0, pontos_q} + PONTOS_INC;
    assign pontos_sat  = pontos_soma[16] ? 16'hFFFF : pontos_soma[15:0];

    // State register plus registered game outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            estado_q    <= IDLE;
            pausa_q     <= 1'b1;
            reinicia_q  <= 1'b0;
            inicia_q    <= 1'b0;
            vidas_q     <= VIDAS_INI;
            pontos_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            estado_q    <= estado_d;
            pausa_q     <= pausa_d;
            reinicia_q  <= reinicia_d;
            inicia_q    <= inicia_d;
            vidas_q     <= vidas_d;
            pontos_q    <= pontos_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state selection; ball loss outranks level clear, which outranks pause.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            IDLE, FIM, VITORIA: begin
                if (start_press) estado_d = SERVE;
            end
            SERVE: begin
                if (start_press) estado_d = PLAY;
            end
            PLAY: begin
                if (bola_perdida) begin
                    estado_d = (vidas_q <= 2'd1) ? FIM : PERDEU;
                end else if (sem_blocos) begin
                    estado_d = VITORIA;
                end else if (pause_press) begin
                    estado_d = PAUSADO;
                end
            end
            PAUSADO: begin
                if (pause_press) estado_d = PLAY;
            end
            PERDEU: begin
                if (tick_frame_q && (frame_cnt_q == FRAME_LAST)) estado_d = SERVE;
            end
            default: estado_d = IDLE;
        endcase
    end

    // Output, lives, score and delay-counter updates for the coming edge.
    always_comb begin
        reinicia_d  = 1'b0;
        inicia_d    = 1'b0;
        vidas_d     = vidas_q;
        pontos_d    = pontos_q;
        frame_cnt_d = frame_cnt_q;
        pausa_d     = !((estado_d == SERVE) || (estado_d == PLAY));
        case (estado_q)
            IDLE, FIM, VITORIA: begin
                if (start_press) begin
                    reinicia_d = 1'b1;
                    vidas_d    = VIDAS_INI;
                    pontos_d   = '0;
                end
            end
            SERVE: begin
                if (start_press) inicia_d = 1'b1;
            end
            PLAY: begin
                if (bloco_destruido) pontos_d = pontos_sat;
                if (bola_perdida) begin
                    vidas_d     = (vidas_q == 2'd0) ? 2'd0 : vidas_q - 2'd1;
                    frame_cnt_d = '0;
                end
            end
            PERDEU: begin
                if (tick_frame_q) frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            end
            default: ;
        endcase
    end

    assign estado        = estado_q;
    assign pausa         = pausa_q;
    assign reiniciarJogo = reinicia_q;
    assign iniciarBola   = inicia_q;
    assign vidas         = vidas_q;
    assign pontos        = pontos_q;
    assign tick_frame    = tick_frame_q;

endmodule

// File: tb/tb_controle_jogo.sv
// Scoreboard bench for controle_jogo: a rule-level game model predicts every
// cycle's outputs, a monitor compares them against the DUT.
module tb_controle_jogo;

    localparam int TD = 4;
    localparam int AF = 2;
    localparam int VI = 3;
    localparam int PB = 10;

    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_PAUSE = 3;
    localparam int S_LOST  = 4;
    localparam int S_FIM   = 5;
    localparam int S_VIT   = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  keysout = 4'h0;
    logic        bola_perdida = 1'b0;
    logic        bloco_destruido = 1'b0;
    logic        sem_blocos = 1'b0;
    logic        pausa;
    logic        reiniciarJogo;
    logic        iniciarBola;
    logic [1:0]  vidas;
    logic [15:0] pontos;
    logic [2:0]  estado;
    logic        tick_frame;

    always #5 clk = ~clk;

    controle_jogo #(
        .VIDAS_INICIAIS(VI),
        .TICK_DIV(TD),
        .PONTOS_BLOCO(PB),
        .ATRASO_FRAMES(AF)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .keysout(keysout),
        .bola_perdida(bola_perdida),
        .bloco_destruido(bloco_destruido),
        .sem_blocos(sem_blocos),
        .pausa(pausa),
        .reiniciarJogo(reiniciarJogo),
        .iniciarBola(iniciarBola),
        .vidas(vidas),
        .pontos(pontos),
        .estado(estado),
        .tick_frame(tick_frame)
    );

    typedef struct {
        int estado;
        int pausa;
        int reinic;
        int inicia;
        int vidas;
        int pontos;
        int tick;
    } exp_t;

    exp_t sbq[$];
    int errors = 0;
    int checks = 0;

    // Game model state
    int m_state = S_IDLE;
    int m_vidas = VI;
    int m_pontos = 0;
    int m_phase = 0;
    int m_frames = 0;
    bit m_tick = 0;
    bit m_reinic = 0;
    bit m_inicia = 0;
    bit m_prev2 = 0;
    bit m_prev3 = 0;

    function automatic void chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    // Applies the game rules for one clock edge given the inputs seen at it.
    task automatic model(input logic [3:0] k, input bit bp, input bit bd, input bit sb, input bit rs);
        bit st;
        bit pz;
        bit old_tick;
        if (rs) begin
            m_state  = S_IDLE;
            m_vidas  = VI;
            m_pontos = 0;
            m_phase  = 0;
            m_tick   = 0;
            m_frames = 0;
            m_reinic = 0;
            m_inicia = 0;
        end else begin
            st = k[2] && !m_prev2;
            pz = k[3] && !m_prev3;
            old_tick = m_tick;
            m_reinic = 0;
            m_inicia = 0;
            case (m_state)
                S_IDLE, S_FIM, S_VIT: if (st) begin
                    m_state = S_SERVE; m_reinic = 1; m_vidas = VI; m_pontos = 0;
                end
                S_SERVE: if (st) begin
                    m_state = S_PLAY; m_inicia = 1;
                end
                S_PLAY: begin
                    if (bd) m_pontos = (m_pontos + PB > 65535) ? 65535 : m_pontos + PB;
                    if (bp) begin
                        m_vidas  = (m_vidas > 0) ? m_vidas - 1 : 0;
                        m_state  = (m_vidas == 0) ? S_FIM : S_LOST;
                        m_frames = 0;
                    end else if (sb) begin
                        m_state = S_VIT;
                    end else if (pz) begin
                        m_state = S_PAUSE;
                    end
                end
                S_PAUSE: if (pz) m_state = S_PLAY;
                S_LOST: if (old_tick) begin
                    m_frames++;
                    if (m_frames >= AF) m_state = S_SERVE;
                end
                default: m_state = S_IDLE;
            endcase
            m_phase = (m_phase + 1) % TD;
            m_tick  = (m_phase == 0);
        end
        m_prev2 = k[2];
        m_prev3 = k[3];
    endtask

    task automatic step(input logic [3:0] k, input bit bp, input bit bd, input bit sb, input bit rs);
        exp_t e;
        @(negedge clk);
        keysout         = k;
        bola_perdida    = bp;
        bloco_destruido = bd;
        sem_blocos      = sb;
        reset           = rs;
        model(k, bp, bd, sb, rs);
        e.estado = m_state;
        e.pausa  = (m_state == S_SERVE || m_state == S_PLAY) ? 0 : 1;
        e.reinic = int'(m_reinic);
        e.inicia = int'(m_inicia);
        e.vidas  = m_vidas;
        e.pontos = m_pontos;
        e.tick   = int'(m_tick);
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'h0, 0, 0, 0, 0);
    endtask

    task automatic press_start();
        step(4'h4, 0, 0, 0, 0);
        step(4'h0, 0, 0, 0, 0);
    endtask

    task automatic press_pause();
        step(4'h8, 0, 0, 0, 0);
        step(4'h0, 0, 0, 0, 0);
    endtask

    // Monitor: compares every registered output once per cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("estado", 32'(estado), e.estado);
                chk("pausa", 32'(pausa), e.pausa);
                chk("reiniciarJogo", 32'(reiniciarJogo), e.reinic);
                chk("iniciarBola", 32'(iniciarBola), e.inicia);
                chk("vidas", 32'(vidas), e.vidas);
                chk("pontos", 32'(pontos), e.pontos);
                chk("tick_frame", 32'(tick_frame), e.tick);
            end
        end
    end

    initial begin
        logic [3:0] k;
        // reset, with start held across release
        step(4'h0, 0, 0, 0, 1);
        step(4'h0, 0, 0, 0, 1);
        step(4'h4, 0, 0, 0, 1);
        step(4'h4, 0, 0, 0, 0);
        step(4'h4, 0, 0, 0, 0);
        idle(2);
        // start -> SERVE, start -> PLAY
        press_start();
        idle(1);
        press_start();
        idle(1);
        // three blocks -> 30 points
        for (int i = 0; i < 3; i++) begin
            step(4'h0, 0, 1, 0, 0);
            step(4'h0, 0, 0, 0, 0);
        end
        // pause held 10 cycles, blocks and losses ignored while paused
        for (int i = 0; i < 10; i++) step(4'h8, 0, (i % 2 == 1), 0, 0);
        step(4'h0, 1, 1, 0, 0);
        step(4'h4, 0, 0, 0, 0);
        step(4'h0, 0, 0, 0, 0);
        press_pause();
        idle(2);
        // lose all three lives
        for (int l = 0; l < 3; l++) begin
            step(4'h0, 1, 0, 0, 0);
            idle(12);
            if (l < 2) begin
                press_start();
                idle(1);
            end
        end
        // restart from FIM, then simultaneous loss/clear/pause
        press_start();
        press_start();
        step(4'h8, 1, 0, 1, 0);
        step(4'h0, 0, 0, 0, 0);
        idle(12);
        press_start();
        step(4'h0, 0, 0, 1, 0);
        idle(2);
        press_start();
        idle(1);
        // score saturation
        press_start();
        for (int i = 0; i < 6556; i++) begin
            step(4'h0, 0, 1, 0, 0);
            step(4'h0, 0, 0, 0, 0);
        end
        // reset in the middle of the post-loss delay
        step(4'h0, 1, 0, 0, 0);
        idle(3);
        step(4'h0, 0, 0, 0, 1);
        idle(12);
        // randomized play
        k = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) == 0) k[2] = ~k[2];
            if ($urandom_range(4) == 0) k[3] = ~k[3];
            k[1:0] = 2'($urandom_range(3));
            step(k, ($urandom_range(39) == 0), ($urandom_range(3) == 0),
                 ($urandom_range(59) == 0), ($urandom_range(299) == 0));
        end
        idle(1);
        repeat (3) @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
